// File: rtl/cv32e40x_pkg.sv
// Shared types for the data-side arbiter: OBI request/response payloads,
// requester IDs and arbiter FSM states.
package cv32e40x_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } data_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } data_resp_t;

  typedef enum logic {ARB_M0 = 1'b0, ARB_M1 = 1'b1} data_arb_id_e;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCKED = 1'b1} data_arb_state_e;

  function automatic logic [1:0] arb_onehot(input data_arb_id_e id);
    logic [1:0] oh;
    case (id)
      ARB_M0:  oh = 2'b01;
      ARB_M1:  oh = 2'b10;
      default: oh = 2'b00;
    endcase
    return oh;
  endfunction

  function automatic data_arb_id_e arb_other(input data_arb_id_e id);
    data_arb_id_e o;
    case (id)
      ARB_M0:  o = ARB_M1;
      ARB_M1:  o = ARB_M0;
      default: o = ARB_M0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/cv32e40x_data_arb_id_fifo.sv
// In-order FIFO of requester IDs, one entry per accepted-but-unanswered
// bus transaction. Pointers wrap modulo DEPTH.
module cv32e40x_data_arb_id_fifo
  import cv32e40x_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  data_arb_id_e push_id,
  output data_arb_id_e head_id,
  output logic         empty,
  output logic         full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_W'(DEPTH - 1)) begin
      n = {PTR_W{1'b0}};
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

  assign head_id = data_arb_id_e'(mem_q[rptr_q]);
  assign empty   = (cnt_q == {CNT_W{1'b0}});
  assign full    = (cnt_q == CNT_W'(DEPTH));

  // Next-state for storage, pointers and occupancy count
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      mem_d[wptr_q] = push_id;
      wptr_d        = ptr_inc(wptr_q);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= {DEPTH{1'b0}};
      wptr_q <= {PTR_W{1'b0}};
      rptr_q <= {PTR_W{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/cv32e40x_data_arbiter.sv
// Two-requester OBI data-port arbiter with in-order response routing.
// Define DATA_ARB_RR_EN for round-robin; otherwise m0 has fixed priority.
module cv32e40x_data_arbiter
  import cv32e40x_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            m_req_i,
  input  data_req_t [1:0]       m_req_data_i,
  output logic [1:0]            m_gnt_o,
  output logic [1:0]            m_rvalid_o,
  output data_resp_t            m_resp_o,
  output logic                  bus_req_o,
  output data_req_t             bus_req_data_o,
  input  logic                  bus_gnt_i,
  input  logic                  bus_rvalid_i,
  input  data_resp_t            bus_resp_i,
  output logic                  spurious_o
);

  data_arb_state_e state_q, state_d;
  data_arb_id_e    locked_id_q, locked_id_d;
  data_arb_id_e    winner, sel_id, head_id;
  logic            spurious_q, spurious_d;
  logic            bus_req, grant, pop;
  logic            fifo_empty, fifo_full;
`ifdef DATA_ARB_RR_EN
  data_arb_id_e    rr_q, rr_d;
`endif

  cv32e40x_data_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (grant),
    .pop     (pop),
    .push_id (sel_id),
    .head_id (head_id),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Winner selection when arbitrating fresh requests in IDLE
  always_comb begin
`ifdef DATA_ARB_RR_EN
    if (m_req_i == 2'b11) begin
      winner = rr_q;
    end else if (m_req_i[0]) begin
      winner = ARB_M0;
    end else begin
      winner = ARB_M1;
    end
`else
    if (m_req_i[0]) begin
      winner = ARB_M0;
    end else begin
      winner = ARB_M1;
    end
`endif
  end

  // Arbitration FSM next state; a stalled winner stays locked until granted
  always_comb begin
    state_d     = state_q;
    locked_id_d = locked_id_q;
    sel_id      = ARB_M0;
    bus_req     = 1'b0;
    grant       = 1'b0;
    if (rst) begin
      state_d = ARB_IDLE;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if ((m_req_i != 2'b00) && !fifo_full) begin
            sel_id  = winner;
            bus_req = 1'b1;
            if (bus_gnt_i) begin
              grant = 1'b1;
            end else begin
              state_d     = ARB_LOCKED;
              locked_id_d = winner;
            end
          end else begin
            state_d = ARB_IDLE;
          end
        end
        ARB_LOCKED: begin
          sel_id  = locked_id_q;
          bus_req = 1'b1;
          if (bus_gnt_i) begin
            grant   = 1'b1;
            state_d = ARB_IDLE;
          end else begin
            state_d = ARB_LOCKED;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  // Response routing: pop only a non-empty FIFO so a same-cycle push is invisible
  always_comb begin
    pop        = !rst && bus_rvalid_i && !fifo_empty;
    spurious_d = !rst && bus_rvalid_i && fifo_empty;
    if (pop) begin
      m_rvalid_o = arb_onehot(head_id);
    end else begin
      m_rvalid_o = 2'b00;
    end
  end

`ifdef DATA_ARB_RR_EN
  // Round-robin pointer moves only on a grant
  always_comb begin
    if (grant) begin
      rr_d = arb_other(sel_id);
    end else begin
      rr_d = rr_q;
    end
  end
`endif

  assign bus_req_o      = bus_req;
  assign bus_req_data_o = bus_req ? m_req_data_i[sel_id] : {$bits(data_req_t){1'b0}};
  assign m_gnt_o        = grant ? arb_onehot(sel_id) : 2'b00;
  assign m_resp_o       = bus_resp_i;
  assign spurious_o     = spurious_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      locked_id_q <= ARB_M0;
      spurious_q  <= 1'b0;
`ifdef DATA_ARB_RR_EN
      rr_q        <= ARB_M0;
`endif
    end else begin
      state_q     <= state_d;
      locked_id_q <= locked_id_d;
      spurious_q  <= spurious_d;
`ifdef DATA_ARB_RR_EN
      rr_q        <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_cv32e40x_data_arbiter.sv
// Directed self-checking bench for cv32e40x_data_arbiter (MAX_OUTSTANDING=2).
module tb_cv32e40x_data_arbiter;
  import cv32e40x_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      m_req;
  data_req_t [1:0] m_req_data;
  logic [1:0]      m_gnt;
  logic [1:0]      m_rvalid;
  data_resp_t      m_resp;
  logic            bus_req;
  data_req_t       bus_req_data;
  logic            bus_gnt;
  logic            bus_rvalid;
  data_resp_t      bus_resp;
  logic            spurious;

  int total = 0;
  int bad   = 0;

  data_req_t  p0, p1;
  data_resp_t r0, r1, r2;
  logic [1:0] exp_g [4];

  always #5 clk = ~clk;

  cv32e40x_data_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .m_req_i        (m_req),
    .m_req_data_i   (m_req_data),
    .m_gnt_o        (m_gnt),
    .m_rvalid_o     (m_rvalid),
    .m_resp_o       (m_resp),
    .bus_req_o      (bus_req),
    .bus_req_data_o (bus_req_data),
    .bus_gnt_i      (bus_gnt),
    .bus_rvalid_i   (bus_rvalid),
    .bus_resp_i     (bus_resp),
    .spurious_o     (spurious)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv, input data_resp_t rsp);
    m_req      = req;
    bus_gnt    = gnt;
    bus_rvalid = rv;
    bus_resp   = rsp;
    #4;
  endtask

  initial begin
    p0 = '{addr: 32'h0000_1000, we: 1'b1, be: 4'hF, wdata: 32'hA5A5_0000};
    p1 = '{addr: 32'h0000_2004, we: 1'b0, be: 4'h3, wdata: 32'h5A5A_1111};
    r0 = '{rdata: 32'hDEAD_0000, err: 1'b0};
    r1 = '{rdata: 32'hBEEF_0001, err: 1'b1};
    r2 = '{rdata: 32'hCAFE_0002, err: 1'b0};
    m_req_data[0] = p0;
    m_req_data[1] = p1;
`ifdef DATA_ARB_RR_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif

    // Outputs held at zero while reset is asserted, even with live inputs
    rst = 1'b1;
    m_req = 2'b11; bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_resp = r0;
    tick(); tick();
    drive(2'b11, 1'b1, 1'b1, r0);
    chk("rst_bus_req", 96'(bus_req), 96'(1'b0));
    chk("rst_gnt", 96'(m_gnt), 96'(2'b00));
    chk("rst_rvalid", 96'(m_rvalid), 96'(2'b00));
    chk("rst_spurious", 96'(spurious), 96'(1'b0));
    chk("rst_bus_data", 96'(bus_req_data), 96'(0));
    tick();
    rst = 1'b0;
    drive(2'b00, 1'b0, 1'b0, r0);
    chk("post_rst_spurious", 96'(spurious), 96'(1'b0));
    chk("post_rst_bus_req", 96'(bus_req), 96'(1'b0));

    // Ordering: grant m0 then m1, zero-latency request path
    tick(); drive(2'b01, 1'b1, 1'b0, r0);
    chk("ord_req0", 96'(bus_req), 96'(1'b1));
    chk("ord_gnt0", 96'(m_gnt), 96'(2'b01));
    chk("ord_data0", 96'(bus_req_data), 96'(p0));
    tick(); drive(2'b10, 1'b1, 1'b0, r0);
    chk("ord_gnt1", 96'(m_gnt), 96'(2'b10));
    chk("ord_data1", 96'(bus_req_data), 96'(p1));

    // Full: no request even though a pop happens this cycle
    tick(); drive(2'b01, 1'b1, 1'b1, r0);
    chk("full_bus_req", 96'(bus_req), 96'(1'b0));
    chk("full_gnt", 96'(m_gnt), 96'(2'b00));
    chk("ord_rvalid0", 96'(m_rvalid), 96'(2'b01));
    chk("ord_resp0", 96'(m_resp), 96'(r0));

    // Push and pop together: response to old head (m1), m0 becomes head
    tick(); drive(2'b01, 1'b1, 1'b1, r1);
    chk("pp_bus_req", 96'(bus_req), 96'(1'b1));
    chk("pp_gnt", 96'(m_gnt), 96'(2'b01));
    chk("pp_rvalid", 96'(m_rvalid), 96'(2'b10));
    chk("pp_resp", 96'(m_resp), 96'(r1));
    tick(); drive(2'b00, 1'b0, 1'b1, r2);
    chk("pp_newhead", 96'(m_rvalid), 96'(2'b01));
    chk("pp_resp2", 96'(m_resp), 96'(r2));
    chk("pp_no_spur", 96'(spurious), 96'(1'b0));
    tick(); drive(2'b00, 1'b0, 1'b0, r0);
    chk("drained_rvalid", 96'(m_rvalid), 96'(2'b00));
    chk("drained_spur", 96'(spurious), 96'(1'b0));

    // Spurious response on empty FIFO, registered pulse
    tick(); drive(2'b00, 1'b0, 1'b1, r0);
    chk("spur_rvalid", 96'(m_rvalid), 96'(2'b00));
    chk("spur_same_cycle", 96'(spurious), 96'(1'b0));
    tick(); drive(2'b00, 1'b0, 1'b0, r0);
    chk("spur_pulse", 96'(spurious), 96'(1'b1));
    tick(); drive(2'b00, 1'b0, 1'b0, r0);
    chk("spur_clear", 96'(spurious), 96'(1'b0));

    // Reset while LOCKED with one outstanding
    tick(); drive(2'b01, 1'b1, 1'b0, r0);
    chk("rl_gnt0", 96'(m_gnt), 96'(2'b01));
    tick(); drive(2'b10, 1'b0, 1'b0, r0);
    chk("rl_stall_req", 96'(bus_req), 96'(1'b1));
    tick(); drive(2'b11, 1'b0, 1'b0, r0);
    chk("rl_locked_data", 96'(bus_req_data), 96'(p1));
    tick();
    rst = 1'b1;
    drive(2'b11, 1'b1, 1'b0, r0);
    chk("rl_rst_req", 96'(bus_req), 96'(1'b0));
    chk("rl_rst_gnt", 96'(m_gnt), 96'(2'b00));
    tick();
    rst = 1'b0;
    drive(2'b00, 1'b0, 1'b0, r0);
    chk("rl_after_req", 96'(bus_req), 96'(1'b0));
    chk("rl_after_spur", 96'(spurious), 96'(1'b0));
    tick(); drive(2'b00, 1'b0, 1'b1, r1);
    chk("rl_discard_rvalid", 96'(m_rvalid), 96'(2'b00));
    tick(); drive(2'b00, 1'b0, 1'b0, r0);
    chk("rl_discard_spur", 96'(spurious), 96'(1'b1));

    // Contention with grant every cycle; FSM must be back in IDLE
    tick(); drive(2'b11, 1'b1, 1'b0, r0);
    chk("cont_gnt0", 96'(m_gnt), 96'(exp_g[0]));
    for (int i = 1; i < 4; i++) begin
      tick(); drive(2'b11, 1'b1, 1'b1, r2);
      chk($sformatf("cont_gnt%0d", i), 96'(m_gnt), 96'(exp_g[i]));
      chk($sformatf("cont_rv%0d", i), 96'(m_rvalid), 96'(exp_g[i-1]));
    end
    tick(); drive(2'b00, 1'b0, 1'b1, r2);
    chk("cont_rv_last", 96'(m_rvalid), 96'(exp_g[3]));

    // Stall: m1 locked for three cycles while m0 joins
    tick(); drive(2'b10, 1'b0, 1'b0, r0);
    chk("stall_c1_req", 96'(bus_req), 96'(1'b1));
    chk("stall_c1_data", 96'(bus_req_data), 96'(p1));
    chk("stall_c1_gnt", 96'(m_gnt), 96'(2'b00));
    tick(); drive(2'b11, 1'b0, 1'b0, r0);
    chk("stall_c2_data", 96'(bus_req_data), 96'(p1));
    chk("stall_c2_gnt", 96'(m_gnt), 96'(2'b00));
    tick(); drive(2'b11, 1'b0, 1'b0, r0);
    chk("stall_c3_data", 96'(bus_req_data), 96'(p1));
    tick(); drive(2'b11, 1'b1, 1'b0, r0);
    chk("stall_c4_gnt", 96'(m_gnt), 96'(2'b10));
    chk("stall_c4_data", 96'(bus_req_data), 96'(p1));
    tick(); drive(2'b01, 1'b1, 1'b0, r0);
    chk("stall_m0_gnt", 96'(m_gnt), 96'(2'b01));
    chk("stall_m0_data", 96'(bus_req_data), 96'(p0));
    tick(); drive(2'b00, 1'b0, 1'b1, r1);
    chk("stall_rv_m1", 96'(m_rvalid), 96'(2'b10));
    tick(); drive(2'b00, 1'b0, 1'b1, r2);
    chk("stall_rv_m0", 96'(m_rvalid), 96'(2'b01));
    tick(); drive(2'b00, 1'b0, 1'b0, r0);
    chk("stall_empty_req", 96'(bus_req), 96'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
